// File: rtl/can_bit_timing_if.sv
// can_bit_timing_if: signal bundle between the CAN bit-timing front end and its
// frame receiver/transmitter.
//   rx           raw CAN RX pin, asynchronous (1 = recessive)
//   hard_sync_en receiver waiting for SOF; enables hard synchronisation
//   sample_stb   one-cycle pulse at the sample point
//   sample_bit   bus value at the sample point, held between strobes
//   tx_stb       one-cycle pulse at bit start; transmitter drives its next bit
//   bus_idle     high after 11 consecutive recessive samples
// master: the bit-timing block. slave: the receiver/transmitter side.
interface can_bit_timing_if;
  logic rx;
  logic hard_sync_en;
  logic sample_stb;
  logic sample_bit;
  logic tx_stb;
  logic bus_idle;

  modport master (
    input  rx,
    input  hard_sync_en,
    output sample_stb,
    output sample_bit,
    output tx_stb,
    output bus_idle
  );

  modport slave (
    output rx,
    output hard_sync_en,
    input  sample_stb,
    input  sample_bit,
    input  tx_stb,
    input  bus_idle
  );
endinterface

// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN bit-timing and sampling front end.
// Synchronises the RX pin, divides clk into time quanta, and runs the
// SYNC/TSEG1/TSEG2 segment machine with hard sync and SJW-limited resync.
//   clk    system clock, posedge
//   rst_n  synchronous reset, active low
//   bus    can_bit_timing_if.master (rx, hard_sync_en in; sample_stb,
//          sample_bit, tx_stb, bus_idle out)
module can_bit_timing #(
  parameter int unsigned PRESCALER = 5,
  parameter int unsigned TSEG1     = 13,
  parameter int unsigned TSEG2     = 2,
  parameter int unsigned SJW       = 1
) (
  input logic              clk,
  input logic              rst_n,
  can_bit_timing_if.master bus
);

  localparam int unsigned QW   = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam int unsigned SegW = 5;
  localparam int unsigned ExtW = 3;

  localparam logic [QW-1:0]   QMax      = QW'(PRESCALER - 1);
  localparam logic [SegW-1:0] Tseg1Last = SegW'(TSEG1 - 1);
  localparam logic [SegW-1:0] Tseg2Last = SegW'(TSEG2 - 1);
  localparam logic [SegW-1:0] Tseg2Len  = SegW'(TSEG2);
  localparam logic [SegW-1:0] SjwSeg    = SegW'(SJW);
  localparam logic [ExtW-1:0] SjwExt    = ExtW'(SJW);
  localparam logic [3:0]      IdleMax   = 4'd11;

  typedef enum logic [1:0] {StSync, StTseg1, StTseg2} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [QW-1:0]   q_cnt_q;
  logic [SegW-1:0] seg_cnt_q, seg_cnt_d;
  logic [ExtW-1:0] ext_q, ext_d;
  logic            resync_done_q, resync_done_d;
  logic            sample_bit_q, sample_bit_d;
  logic [3:0]      idle_cnt_q, idle_cnt_d;

  logic            tq_stb;
  logic            edge_det;
  logic            sample_stb_c, tx_stb_c;
  logic            sample_stb_g;

  assign tq_stb   = (q_cnt_q == '0);
  // Recessive at the previous quantum, dominant now.
  assign edge_det = tq_stb & rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      q_cnt_q       <= QMax;
      state_q       <= StSync;
      seg_cnt_q     <= '0;
      ext_q         <= '0;
      resync_done_q <= 1'b0;
      sample_bit_q  <= 1'b1;
      idle_cnt_q    <= '0;
    end else begin
      rx_meta_q     <= bus.rx;
      rx_s_q        <= rx_meta_q;
      // Free-running: sync events never realign the quantum grid.
      q_cnt_q       <= tq_stb ? QMax : q_cnt_q - QW'(1);
      if (tq_stb) begin
        rx_prev_q <= rx_s_q;
      end
      state_q       <= state_d;
      seg_cnt_q     <= seg_cnt_d;
      ext_q         <= ext_d;
      resync_done_q <= resync_done_d;
      sample_bit_q  <= sample_bit_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  always_comb begin
    logic            resync;
    logic            early_sync;
    logic [ExtW-1:0] ext_eff;
    logic [SegW-1:0] seg_eff;
    logic [SegW-1:0] seg_plus;

    state_d       = state_q;
    seg_cnt_d     = seg_cnt_q;
    ext_d         = ext_q;
    resync_done_d = resync_done_q;
    sample_bit_d  = sample_bit_q;
    idle_cnt_d    = idle_cnt_q;
    sample_stb_c  = 1'b0;
    tx_stb_c      = 1'b0;
    resync        = 1'b0;
    early_sync    = 1'b0;
    ext_eff       = ext_q;
    seg_eff       = seg_cnt_q;
    seg_plus      = seg_cnt_q + SegW'(1);

    if (tq_stb) begin
      if (edge_det && bus.hard_sync_en) begin
        // Edge quantum becomes SYNC_SEG of a fresh bit.
        state_d       = StTseg1;
        seg_cnt_d     = '0;
        ext_d         = '0;
        resync_done_d = 1'b1;
      end else begin
        resync = edge_det && !resync_done_q;
        if (resync) begin
          resync_done_d = 1'b1;
        end
        unique case (state_q)
          StSync: begin
            state_d   = StTseg1;
            seg_cnt_d = '0;
          end
          StTseg1: begin
            // Late edge: stretch TSEG1 by the phase error, capped at SJW.
            if (resync) begin
              ext_eff = (seg_plus < SjwSeg) ? seg_plus[ExtW-1:0] : SjwExt;
            end
            ext_d = ext_eff;
            if (seg_cnt_q == Tseg1Last + SegW'(ext_eff)) begin
              sample_stb_c = 1'b1;
              sample_bit_d = rx_s_q;
              state_d      = StTseg2;
              seg_cnt_d    = '0;
            end else begin
              seg_cnt_d = seg_plus;
            end
          end
          StTseg2: begin
            if (resync) begin
              if (Tseg2Len - seg_cnt_q <= SjwSeg) begin
                // Early edge within reach: treat this quantum as SYNC_SEG.
                early_sync = 1'b1;
                state_d    = StTseg1;
                seg_cnt_d  = '0;
                ext_d      = '0;
                tx_stb_c   = 1'b1;
              end else begin
                seg_eff = seg_cnt_q + SjwSeg;
              end
            end
            if (!early_sync) begin
              if (seg_eff >= Tseg2Last) begin
                state_d       = StSync;
                tx_stb_c      = 1'b1;
                ext_d         = '0;
                resync_done_d = 1'b0;
              end else begin
                seg_cnt_d = seg_eff + SegW'(1);
              end
            end
          end
          default: begin
            state_d   = StSync;
            seg_cnt_d = '0;
          end
        endcase
      end
    end

    if (sample_stb_c) begin
      if (rx_s_q) begin
        idle_cnt_d = (idle_cnt_q == IdleMax) ? IdleMax : idle_cnt_q + 4'd1;
      end else begin
        idle_cnt_d = '0;
      end
    end
  end

  // Strobes are decoded combinationally so they coincide with tq_stb; gating
  // with rst_n keeps them quiet during any reset cycle.
  assign sample_stb_g   = rst_n & sample_stb_c;
  assign bus.sample_stb = sample_stb_g;
  assign bus.tx_stb     = rst_n & tx_stb_c;
  assign bus.sample_bit = sample_stb_g ? rx_s_q : sample_bit_q;
  assign bus.bus_idle   = (idle_cnt_q == IdleMax);

endmodule

// File: doc/can_bit_timing.md
# can_bit_timing

CAN bit-timing and sampling front end. It sits directly upstream of the CAN frame receiver and transmitter. It synchronises the raw bus pin and divides the system clock into time quanta. It then runs the SYNC/TSEG1/TSEG2 bit-segment state machine with hard synchronisation and SJW-limited resynchronisation, and outputs a one-cycle sample strobe with the sampled bit, a bit-start strobe for the transmitter, and a bus-idle flag.

## Interface
- PRESCALER, 5: clk cycles per time quantum (tq); ≥1.
- TSEG1, 13: nominal TSEG1 length in tq (prop + phase1); 2..16.
- TSEG2, 2: TSEG2 length in tq (phase2); 1..8.
- SJW, 1: resync jump width in tq; 1..min(4, TSEG2).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active low.
- rx  in  1  raw CAN RX pin, asynchronous; 1 = recessive.
- hard_sync_en  in  1  from receiver: high while waiting for SOF (bus idle / intermission).
- sample_stb  out  1  one-cycle pulse at the sample point.
- sample_bit  out  1  bus value at the sample point; valid with sample_stb, held otherwise.
- tx_stb  out  1  one-cycle pulse at bit start (entry to SYNC_SEG); the transmitter drives its next bit here.
- bus_idle  out  1  high after 11 consecutive recessive samples.

## Operation
- Input sync: rx → 2-flop synchroniser → rx_s. Both flops reset to 1.
- Prescaler: q_cnt counts down PRESCALER-1..0. tq_stb is high in the cycle q_cnt==0. The prescaler is free-running and is never reset by sync events.
- Edge detect: at each tq_stb, rx_q <= rx_s. edge = tq_stb & rx_q & ~rx_s, a recessive→dominant transition within the quantum.
- States: SYNC_SEG, TSEG1, TSEG2. Counter seg_cnt counts quanta within the current segment, from 0. ext (0..SJW) is the TSEG1 extension for the current bit.
- On tq_stb with no edge:
  - SYNC_SEG → TSEG1, seg_cnt=0.
  - TSEG1: if seg_cnt == TSEG1+ext-1, pulse sample_stb, set sample_bit=rx_s, go to TSEG2, seg_cnt=0. Else seg_cnt++.
  - TSEG2: if seg_cnt ≥ TSEG2-1, go to SYNC_SEG, pulse tx_stb, set ext=0, clear resync_done. Else seg_cnt++.
- Hard sync (edge & hard_sync_en, in any state): go to TSEG1, seg_cnt=0, ext=0, set resync_done. No tx_stb. Normal segment processing is skipped that quantum.
- Resync applies only when edge & ~hard_sync_en & ~resync_done. It sets resync_done.
  - In SYNC_SEG: no correction.
  - In TSEG1 (late edge): ext = min(seg_cnt+1, SJW); seg_cnt++ as normal. The sample-point compare uses the new ext.
  - In TSEG2 (early edge): e = TSEG2-seg_cnt.
    - If e ≤ SJW: go to TSEG1, seg_cnt=0, pulse tx_stb. The edge quantum acts as SYNC_SEG.
    - Else: seg_cnt += SJW, so the bit ends SJW tq early.
- At most one correction per bit. An edge after resync_done is set is ignored.
- bus_idle: idle_cnt (4 bits) increments on each sample_stb with sample_bit=1 and saturates at 11. It clears on sample_stb with sample_bit=0. bus_idle = (idle_cnt==11).

## Timing
- Reset values: sample_stb=0, tx_stb=0, sample_bit=1, bus_idle=0, state=SYNC_SEG, q_cnt=PRESCALER-1, seg_cnt=0, ext=0, resync_done=0, idle_cnt=0.
- rx → rx_s latency: 2 clk cycles. Edge resolution: 1 tq.
- Nominal bit: (1+TSEG1+TSEG2)·PRESCALER clk = 80 clk at defaults. Sample point: 14/16 tq after bit start.
- Strobes are exactly 1 clk wide and are coincident with tq_stb. sample_stb and tx_stb are never high in the same cycle.
- Reset asserted mid-bit: all state returns to reset values on the next clk. The first tx_stb occurs (1+TSEG1+TSEG2) tq after release, since TSEG2 is reached from SYNC_SEG.
- Resync never changes bit length by more than SJW tq, except for hard sync.

## Test plan
(All with defaults: PRESCALER=5, TSEG1=13, TSEG2=2, SJW=1.)
- Reset, rx=1, hard_sync_en=0 → all outputs at reset values while rst_n=0. After release, sample_stb every 80 clk with sample_bit=1; bus_idle rises on the 11th sample_stb.
- hard_sync_en=1, rx 1→0 mid-TSEG1 → next sample_stb exactly 13 tq after the edge quantum, with sample_bit=0. bus_idle drops on that sample. No tx_stb at the edge.
- hard_sync_en=0, falling edges every 85 clk (late by 1 tq) → each bit has ext=1. sample_stb spacing locks to 85 clk, and the sample stays 14 tq after each edge.
- Falling edge in TSEG2 quantum 1 (e=1 ≤ SJW) → tx_stb in that quantum; the following bit is 75 clk.
- Falling edge in TSEG1 quantum 5 (error 6 > SJW) → ext=1 only, bit is 85 clk. A second edge in the same bit causes no further change.
- Drop rst_n for 1 clk mid-TSEG1 during a hard-synced frame → bus_idle=0, no strobes that cycle. The next tx_stb comes 16 tq after release.
